niosballe_pio_out: RTL
======================

# niosballe_pio_out

Avalon-MM output PIO for the Nios ball subsystem. Software writes a DATA_WIDTH-bit value, such as ball position or paddle flags, that drives `out_port` toward the VGA/game logic. The write can take effect immediately or be double-buffered and committed on the rising edge of an asynchronous frame-sync strobe, so video never sees a half-updated frame. Set/clear aliases allow atomic bit updates, and readback covers the shadow value, the live output and the commit status.

## Interface
Parameters:
- DATA_WIDTH, 11, width of shadow and out_port (1..32)
- RESET_VALUE, 0, value of shadow and out_port after reset

Ports:
- Reset is reset_n, asynchronous, active-low. Clock is clk.
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- frame_sync  in  1  asynchronous frame strobe from the video domain
- out_port  out  DATA_WIDTH  committed output value
- commit_pulse  out  1  one-cycle pulse when a sync-mode commit occurs

## Operation
- The write strobe is `wr = chipselect & ~write_n`. Only writedata[DATA_WIDTH-1:0] is used; higher bits are ignored.
- Register map:
  - addr 0 DATA: a write loads the shadow; a read returns the shadow.
  - addr 1 CTRL: bit0 `sync_mode`, RW; bit1 `pending`, RO. Other bits read 0.
  - addr 2 OUTSET: a write sets bits, `shadow |= wd`. A read returns the live out_port.
  - addr 3 OUTCLR: a write clears bits, `shadow &= ~wd`. A read returns 0.
- Immediate mode (sync_mode=0):
  - Every shadow update also loads out_port at the same edge.
  - pending stays 0.
- Sync mode (sync_mode=1):
  - A shadow update sets pending=1 and leaves out_port unchanged.
  - On a detected frame_sync rising edge with pending=1, out_port takes the shadow value, pending clears and commit_pulse=1 for one cycle.
  - An edge with pending=0 does nothing and produces no pulse.
- frame_sync path: a 2-FF synchronizer, then a delayed copy. The edge condition is `s2 & ~s3`.
- Simultaneous shadow write and commit edge: out_port takes the post-write value, and pending ends at 0.
- CTRL write 1→0 with pending=1: out_port takes the shadow at that edge and pending clears. No commit_pulse.
- CTRL write 0→1: no output change.
- readdata is registered every clk from the address mux, independent of chipselect. Unused upper bits are 0.

## Timing
- Reset values:
  - readdata=0, out_port=RESET_VALUE, shadow=RESET_VALUE.
  - sync_mode=0, pending=0, commit_pulse=0, synchronizer flops=0.
- Register write: the shadow (and out_port in immediate mode) is updated at the clk edge that samples wr. The new value is visible in the following cycle.
- Read latency: 1 cycle. readdata at edge N+1 reflects the address and state at edge N. A read in the cycle after a write returns the new value.
- Sync commit latency: frame_sync high before edge E0 gives s1 at E0, s2 at E1, and out_port/commit_pulse at E2, i.e. the 3rd edge. commit_pulse drops at E3.
- frame_sync high pulses shorter than 1 clk period may be missed. The minimum guaranteed pulse is 2 clk periods.
- A frame_sync that stays high gives only one edge. A new commit needs low then high again.
- Reset mid-operation: pending is lost, out_port returns to RESET_VALUE immediately (asynchronously), and any in-flight edge is discarded.

## Structure
- Package niosballe_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_CTRL=1, ADDR_OUTSET=2, ADDR_OUTCLR=3
  - CTRL bit indices CTRL_SYNC_MODE=0, CTRL_PENDING=1
- Sub-module niosballe_sync_edge: 2-FF synchronizer plus rising-edge detector with asynchronous reset. Ports: clk, reset_n, async_in, rise.
- Top level contains the shadow, out_port, CTRL/pending logic and the read mux.

## Test plan
- Reset:
  - Assert reset_n=0 with RESET_VALUE=0x155, then release.
  - Required: out_port=0x155, readdata=0, CTRL read=0.
- Immediate write:
  - Write 0x2A5 to addr 0.
  - Required: out_port=0x2A5 next cycle. Read addr 0 → 0x2A5, addr 2 → 0x2A5.
- Set/clear:
  - From 0x0F0, write OUTSET 0x00F, then OUTCLR 0x030.
  - Required: out_port=0x0FF, then 0x0CF. Writedata bits [31:11] set have no effect.
- Sync commit:
  - Set CTRL=1, write 0x123.
  - Required: out_port unchanged and CTRL read=0x3.
  - Then raise frame_sync for 4 cycles.
  - Required: out_port=0x123 at the 3rd edge, commit_pulse high for exactly 1 cycle, CTRL read=0x1.
  - A second frame_sync edge with no new write produces no pulse.
- Collision:
  - In sync mode, write 0x3FF on the same edge as the commit edge.
  - Required: out_port=0x3FF and pending=0.
  - Then assert reset_n mid-pending.
  - Required: out_port=RESET_VALUE and pending=0.

Source files
------------

// File: rtl/niosballe_pio_pkg.sv
// Shared constants and helpers for the niosballe output PIO.
package niosballe_pio_pkg;

    // Register map (word addresses on the Avalon-MM slave)
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_OUTSET = 2'd2;
    localparam logic [1:0] ADDR_OUTCLR = 2'd3;

    // CTRL register bit positions
    localparam int unsigned CTRL_SYNC_MODE = 0;
    localparam int unsigned CTRL_PENDING   = 1;

    // Builds the CTRL readback word; all unused bits read as zero.
    function automatic logic [31:0] ctrl_word(input logic sync_mode, input logic pending);
        logic [31:0] w;
        w = 32'd0;
        w[CTRL_SYNC_MODE] = sync_mode;
        w[CTRL_PENDING]   = pending;
        return w;
    endfunction

endpackage

// File: rtl/niosballe_sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe followed by a rising-edge
// detector. A strobe held high produces exactly one rise.
module niosballe_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Next-state for the synchronizer chain and the delayed copy
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and delay flops, cleared asynchronously so an in-flight edge is discarded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/niosballe_pio_out.sv
// Avalon-MM output PIO: shadow register with set/clear aliases, optional
// double-buffering committed on a synchronized frame_sync rising edge.
module niosballe_pio_out
    import niosballe_pio_pkg::*;
#(
    parameter int unsigned                DATA_WIDTH  = 11,
    parameter logic [DATA_WIDTH-1:0]      RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic                  frame_sync,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  commit_pulse
);

    logic                  wr_s;
    logic                  shadow_upd_s;
    logic                  ctrl_wr_s;
    logic                  rise_s;
    logic [DATA_WIDTH-1:0] wd_s;
    logic [31:0]           shadow_ext_s;
    logic [31:0]           out_ext_s;

    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  sync_mode_q, sync_mode_d;
    logic                  pending_q, pending_d;
    logic                  pulse_q, pulse_d;
    logic [31:0]           readdata_q, readdata_d;

    niosballe_sync_edge u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (frame_sync),
        .rise     (rise_s)
    );

    // Bits of writedata above DATA_WIDTH are intentionally ignored
    if (DATA_WIDTH < 32) begin : g_unused_wd
        logic unused_wd_s;
        assign unused_wd_s = ^writedata[31:DATA_WIDTH];
    end

    // Write decode and shadow update (DATA load, OUTSET, OUTCLR)
    always_comb begin
        wr_s         = chipselect & ~write_n;
        wd_s         = writedata[DATA_WIDTH-1:0];
        ctrl_wr_s    = wr_s & (address == ADDR_CTRL);
        shadow_upd_s = wr_s & (address != ADDR_CTRL);
        shadow_d     = shadow_q;
        if (wr_s) begin
            case (address)
                ADDR_DATA:   shadow_d = wd_s;
                ADDR_OUTSET: shadow_d = shadow_q | wd_s;
                ADDR_OUTCLR: shadow_d = shadow_q & ~wd_s;
                default:     shadow_d = shadow_q;
            endcase
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Output, pending and mode control; a write colliding with a commit edge commits the post-write value
    always_comb begin
        out_d       = out_q;
        pending_d   = pending_q;
        pulse_d     = 1'b0;
        sync_mode_d = sync_mode_q;
        if (ctrl_wr_s) begin
            sync_mode_d = writedata[CTRL_SYNC_MODE];
        end else begin
            sync_mode_d = sync_mode_q;
        end
        if (!sync_mode_q) begin
            pending_d = 1'b0;
            if (shadow_upd_s) begin
                out_d = shadow_d;
            end else begin
                out_d = out_q;
            end
        end else if (ctrl_wr_s && !writedata[CTRL_SYNC_MODE]) begin
            // Leaving sync mode flushes any pending value without a pulse
            pending_d = 1'b0;
            if (pending_q) begin
                out_d = shadow_q;
            end else begin
                out_d = out_q;
            end
        end else if (rise_s && (pending_q || shadow_upd_s)) begin
            out_d     = shadow_d;
            pending_d = 1'b0;
            pulse_d   = 1'b1;
        end else if (shadow_upd_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Zero-extended copies of the shadow and live output for readback
    always_comb begin
        shadow_ext_s = 32'd0;
        out_ext_s    = 32'd0;
        shadow_ext_s[DATA_WIDTH-1:0] = shadow_q;
        out_ext_s[DATA_WIDTH-1:0]    = out_q;
    end

    // Read mux, registered every cycle regardless of chipselect
    always_comb begin
        case (address)
            ADDR_DATA:   readdata_d = shadow_ext_s;
            ADDR_CTRL:   readdata_d = ctrl_word(sync_mode_q, pending_q);
            ADDR_OUTSET: readdata_d = out_ext_s;
            ADDR_OUTCLR: readdata_d = 32'd0;
            default:     readdata_d = 32'd0;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q    <= RESET_VALUE;
            out_q       <= RESET_VALUE;
            sync_mode_q <= 1'b0;
            pending_q   <= 1'b0;
            pulse_q     <= 1'b0;
            readdata_q  <= 32'd0;
        end else begin
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            sync_mode_q <= sync_mode_d;
            pending_q   <= pending_d;
            pulse_q     <= pulse_d;
            readdata_q  <= readdata_d;
        end
    end

    assign out_port     = out_q;
    assign commit_pulse = pulse_q;
    assign readdata     = readdata_q;

endmodule
